// File: rtl/descriptor_match.sv
// descriptor_match: pulls groups of four keypoint descriptors from the generator and,
// for each keypoint, sweeps the reference memory to report the nearest reference by L1 distance.
module descriptor_match #(
  parameter int REF_AW = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [10:0]       kpt_num,
  input  logic [REF_AW:0]   ref_num,
  input  logic [16:0]       dist_thresh,
  output logic              descriptor_request,
  input  logic              descriptor_valid,
  input  logic [402:0]      row_col_descpt1,
  input  logic [402:0]      row_col_descpt2,
  input  logic [402:0]      row_col_descpt3,
  input  logic [402:0]      row_col_descpt4,
  output logic [REF_AW-1:0] ref_addr,
  input  logic [383:0]      ref_descpt,
  output logic              match_valid,
  output logic [18:0]       match_row_col,
  output logic [REF_AW-1:0] match_ref_idx,
  output logic [16:0]       match_dist,
  output logic              match_hit,
  output logic              done
);

  typedef enum logic [2:0] {
    S_IDLE, S_REQ, S_SWEEP, S_LAST, S_EMIT, S_DONE
  } state_t;

  localparam logic [16:0]       DIST_MAX = 17'h1FFFF;
  localparam logic [REF_AW-1:0] ADDR_ONE = {{(REF_AW-1){1'b0}}, 1'b1};
  localparam logic [REF_AW:0]   CNT_ONE  = {{REF_AW{1'b0}}, 1'b1};

  state_t state, state_nxt;

  logic [REF_AW:0]   ref_cnt;
  logic [8:0]        grp_left;
  logic [402:0]      desc_buf [4];
  logic [1:0]        q_idx;
  logic [1:0]        nxt_q;
  logic [16:0]       best_dist;
  logic [REF_AW-1:0] best_idx;
  logic              pend_valid;
  logic [REF_AW-1:0] pend_idx;

  logic [383:0]      cur_query;
  logic [16:0]       cur_dist;
  logic              cur_better;
  logic [16:0]       fin_dist;
  logic [REF_AW-1:0] fin_idx;
  logic              last_addr;
  logic              no_refs;
  logic              unused_kpt_rem;

  function automatic logic [16:0] l1_dist(input logic [383:0] a, input logic [383:0] b);
    logic [16:0] acc;
    logic [11:0] da;
    logic [11:0] db;
    acc = '0;
    for (int d = 0; d < 32; d++) begin
      da  = a[383-12*d -: 12];
      db  = b[383-12*d -: 12];
      acc = acc + 17'((da > db) ? (da - db) : (db - da));
    end
    return acc;
  endfunction

  // The last two keypoint bits only describe a partial group, which is never requested.
  assign unused_kpt_rem = ^kpt_num[1:0];

  assign no_refs    = (ref_cnt == '0);
  assign last_addr  = (({1'b0, ref_addr} + CNT_ONE) == ref_cnt);
  assign nxt_q      = q_idx + 2'd1;
  assign cur_query  = desc_buf[q_idx][383:0];
  assign cur_dist   = l1_dist(cur_query, ref_descpt);
  // pend_* tracks the address whose data is arriving this cycle (one-cycle read latency).
  assign cur_better = pend_valid && (cur_dist < best_dist);
  assign fin_dist   = cur_better ? cur_dist : best_dist;
  assign fin_idx    = cur_better ? pend_idx : best_idx;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= S_IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:  if (start) state_nxt = (kpt_num[10:2] == '0) ? S_DONE : S_REQ;
      S_REQ:   if (descriptor_valid) state_nxt = no_refs ? S_EMIT : S_SWEEP;
      S_SWEEP: if (last_addr) state_nxt = S_LAST;
      S_LAST:  state_nxt = S_EMIT;
      S_EMIT: begin
        if (q_idx != 2'd3)         state_nxt = no_refs ? S_EMIT : S_SWEEP;
        else if (grp_left != '0)   state_nxt = S_REQ;
        else                       state_nxt = S_DONE;
      end
      S_DONE:  state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  // Datapath and registered outputs; entering a sweep always restarts address and best-so-far.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      descriptor_request <= 1'b0;
      done               <= 1'b0;
      match_valid        <= 1'b0;
      match_row_col      <= '0;
      match_ref_idx      <= '0;
      match_dist         <= '0;
      match_hit          <= 1'b0;
      ref_addr           <= '0;
      ref_cnt            <= '0;
      grp_left           <= '0;
      q_idx              <= '0;
      best_dist          <= '0;
      best_idx           <= '0;
      pend_valid         <= 1'b0;
      pend_idx           <= '0;
      for (int i = 0; i < 4; i++) desc_buf[i] <= '0;
    end else begin
      descriptor_request <= (state == S_REQ) && !descriptor_valid;
      done               <= (state_nxt == S_DONE);
      match_valid        <= (state_nxt == S_EMIT);
      case (state)
        S_IDLE: begin
          if (start) begin
            ref_cnt  <= ref_num;
            grp_left <= kpt_num[10:2];
          end
        end
        S_REQ: begin
          if (descriptor_valid) begin
            desc_buf[0] <= row_col_descpt1;
            desc_buf[1] <= row_col_descpt2;
            desc_buf[2] <= row_col_descpt3;
            desc_buf[3] <= row_col_descpt4;
            grp_left    <= grp_left - 9'd1;
            q_idx       <= 2'd0;
            ref_addr    <= '0;
            best_dist   <= DIST_MAX;
            best_idx    <= '0;
            pend_valid  <= 1'b0;
            if (no_refs) begin
              match_row_col <= row_col_descpt1[402:384];
              match_ref_idx <= '0;
              match_dist    <= DIST_MAX;
              match_hit     <= (DIST_MAX < dist_thresh);
            end
          end
        end
        S_SWEEP: begin
          if (cur_better) begin
            best_dist <= cur_dist;
            best_idx  <= pend_idx;
          end
          pend_valid <= 1'b1;
          pend_idx   <= ref_addr;
          if (!last_addr) ref_addr <= ref_addr + ADDR_ONE;
        end
        S_LAST: begin
          match_row_col <= desc_buf[q_idx][402:384];
          match_ref_idx <= fin_idx;
          match_dist    <= fin_dist;
          match_hit     <= (fin_dist < dist_thresh);
        end
        S_EMIT: begin
          if (q_idx != 2'd3) begin
            q_idx      <= nxt_q;
            ref_addr   <= '0;
            best_dist  <= DIST_MAX;
            best_idx   <= '0;
            pend_valid <= 1'b0;
            if (no_refs) begin
              match_row_col <= desc_buf[nxt_q][402:384];
              match_ref_idx <= '0;
              match_dist    <= DIST_MAX;
              match_hit     <= (DIST_MAX < dist_thresh);
            end
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_descriptor_match.sv
// tb_descriptor_match: drives descriptor_match with directed and randomized frames and checks
// every match record, its timing and the handshake against a brute-force nearest-neighbour model.
module tb_descriptor_match;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         start;
  logic [10:0]  kpt_num;
  logic [8:0]   ref_num;
  logic [16:0]  dist_thresh;
  logic         descriptor_request;
  logic         descriptor_valid;
  logic [402:0] row_col_descpt1, row_col_descpt2, row_col_descpt3, row_col_descpt4;
  logic [7:0]   ref_addr;
  logic [383:0] ref_descpt;
  logic         match_valid;
  logic [18:0]  match_row_col;
  logic [7:0]   match_ref_idx;
  logic [16:0]  match_dist;
  logic         match_hit;
  logic         done;

  descriptor_match #(.REF_AW(8)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .kpt_num(kpt_num), .ref_num(ref_num),
    .dist_thresh(dist_thresh), .descriptor_request(descriptor_request),
    .descriptor_valid(descriptor_valid),
    .row_col_descpt1(row_col_descpt1), .row_col_descpt2(row_col_descpt2),
    .row_col_descpt3(row_col_descpt3), .row_col_descpt4(row_col_descpt4),
    .ref_addr(ref_addr), .ref_descpt(ref_descpt), .match_valid(match_valid),
    .match_row_col(match_row_col), .match_ref_idx(match_ref_idx), .match_dist(match_dist),
    .match_hit(match_hit), .done(done)
  );

  always #5 clk = ~clk;

  logic [383:0] ref_mem [256];
  logic [402:0] desc_q [$];
  int total_checks = 0;
  int bad_checks = 0;
  int cyc = 0;
  int start_cyc = 0;
  int done_cnt = 0;
  int done_cyc = 0;
  int req_cnt = 0;
  bit req_prev = 1'b0;
  int gen_delay = 0;
  int gen_stray = 0;
  int req_drop = 0;
  int          obs_cyc [$];
  logic [18:0] obs_rc [$];
  logic [7:0]  obs_idx [$];
  logic [16:0] obs_dist [$];
  logic        obs_hit [$];
  int          cap_cyc [$];

  always @(posedge clk) ref_descpt <= ref_mem[ref_addr];

  function automatic logic [383:0] flat_dims(input int v);
    logic [383:0] r;
    for (int k = 0; k < 32; k++) r[12*k +: 12] = 12'(v);
    return r;
  endfunction

  function automatic logic [383:0] rand_dims();
    logic [383:0] r;
    for (int k = 0; k < 32; k++) r[12*k +: 12] = 12'($urandom_range(0, 4095));
    return r;
  endfunction

  function automatic logic [402:0] rand_desc();
    return {9'($urandom), 10'($urandom), rand_dims()};
  endfunction

  function automatic int l1(input logic [383:0] a, input logic [383:0] b);
    int s = 0;
    for (int k = 0; k < 32; k++) begin
      int x, y;
      x = int'(a[12*k +: 12]);
      y = int'(b[12*k +: 12]);
      s += (x > y) ? x - y : y - x;
    end
    return s;
  endfunction

  task automatic checkOutput(input string tag, input logic [63:0] got, input logic [63:0] want);
    total_checks++;
    if (got !== want) begin
      bad_checks++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, got, want);
    end
  endtask

  task automatic checkQuiet(input string tag);
    checkOutput(tag, {descriptor_request, ref_addr, match_valid, match_row_col,
                      match_ref_idx, match_dist, match_hit, done}, 64'd0);
  endtask

  // Monitor: samples on the falling edge, well away from the DUT's active edge.
  initial begin
    forever begin
      @(negedge clk);
      cyc++;
      if (start === 1'b1) start_cyc = cyc;
      if (match_valid === 1'b1) begin
        obs_cyc.push_back(cyc);
        obs_rc.push_back(match_row_col);
        obs_idx.push_back(match_ref_idx);
        obs_dist.push_back(match_dist);
        obs_hit.push_back(match_hit);
      end
      if (done === 1'b1) begin
        done_cnt++;
        done_cyc = cyc;
      end
      if (descriptor_request === 1'b1 && !req_prev) req_cnt++;
      req_prev = (descriptor_request === 1'b1);
      if (descriptor_valid === 1'b1 && descriptor_request === 1'b1) cap_cyc.push_back(cyc);
    end
  end

  // Descriptor generator: answers each request after gen_delay cycles, optionally followed
  // by a stray strobe of inverted data gen_stray cycles later.
  initial begin
    int stray_wait;
    stray_wait = 0;
    descriptor_valid = 1'b0;
    row_col_descpt1 = '0;
    row_col_descpt2 = '0;
    row_col_descpt3 = '0;
    row_col_descpt4 = '0;
    forever begin
      @(posedge clk); #1;
      descriptor_valid = 1'b0;
      if (descriptor_request === 1'b1 && desc_q.size() >= 4) begin
        repeat (gen_delay) begin
          @(posedge clk); #1;
          if (descriptor_request !== 1'b1) req_drop++;
        end
        row_col_descpt1 = desc_q.pop_front();
        row_col_descpt2 = desc_q.pop_front();
        row_col_descpt3 = desc_q.pop_front();
        row_col_descpt4 = desc_q.pop_front();
        descriptor_valid = 1'b1;
        stray_wait = gen_stray;
      end else if (stray_wait > 0) begin
        stray_wait--;
        if (stray_wait == 0) begin
          row_col_descpt1 = ~row_col_descpt1;
          row_col_descpt2 = ~row_col_descpt2;
          row_col_descpt3 = ~row_col_descpt3;
          row_col_descpt4 = ~row_col_descpt4;
          descriptor_valid = 1'b1;
        end
      end
    end
  end

  // Runs one frame over the descriptors already queued in desc_q and checks all records.
  task automatic applyStimulus(input string name, input int kpt, input int rn, input int thresh,
                               input int delay, input int stray, input bit poke);
    int g, n, waited, gap;
    logic [18:0] e_rc [$];
    int e_idx [$];
    int e_dist [$];
    bit e_hit [$];
    g = kpt / 4;
    for (int j = 0; j < 4 * g; j++) begin
      int best, bi, d;
      best = 'h1FFFF;
      bi = 0;
      for (int i = 0; i < rn; i++) begin
        d = l1(desc_q[j][383:0], ref_mem[i]);
        if (d < best) begin
          best = d;
          bi = i;
        end
      end
      e_rc.push_back(desc_q[j][402:384]);
      e_idx.push_back(bi);
      e_dist.push_back(best);
      e_hit.push_back(best < thresh);
    end
    obs_cyc.delete(); obs_rc.delete(); obs_idx.delete(); obs_dist.delete(); obs_hit.delete();
    cap_cyc.delete();
    req_cnt = 0; done_cnt = 0; req_drop = 0;
    gen_delay = delay; gen_stray = stray;

    @(posedge clk); #1;
    kpt_num = 11'(kpt); ref_num = 9'(rn); dist_thresh = 17'(thresh); start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0; kpt_num = 11'($urandom); ref_num = 9'($urandom);
    waited = 0;
    while (done_cnt == 0 && waited < 4000) begin
      @(posedge clk); #1;
      waited++;
      start = poke && (waited == 7);
    end
    start = 1'b0;
    checkOutput({name, "/finished"}, done_cnt != 0, 1);
    repeat (3) @(posedge clk);
    #1;
    checkOutput({name, "/done_once"}, done_cnt, 1);
    checkOutput({name, "/requests"}, req_cnt, g);
    checkOutput({name, "/records"}, obs_cyc.size(), 4 * g);
    if (g == 0) checkOutput({name, "/done_lat"}, done_cyc - start_cyc, 1);
    else if (obs_cyc.size() > 0) checkOutput({name, "/done_lat"}, done_cyc - obs_cyc[$], 1);
    if (delay > 0) checkOutput({name, "/req_held"}, req_drop, 0);
    n = (obs_cyc.size() < 4 * g) ? obs_cyc.size() : 4 * g;
    gap = (rn == 0) ? 1 : rn + 2;
    for (int i = 0; i < n; i++) begin
      checkOutput($sformatf("%s/rc%0d", name, i), obs_rc[i], e_rc[i]);
      checkOutput($sformatf("%s/idx%0d", name, i), obs_idx[i], e_idx[i]);
      checkOutput($sformatf("%s/dist%0d", name, i), obs_dist[i], e_dist[i]);
      checkOutput($sformatf("%s/hit%0d", name, i), obs_hit[i], e_hit[i]);
      if (i % 4 != 0)
        checkOutput($sformatf("%s/gap%0d", name, i), obs_cyc[i] - obs_cyc[i-1], gap);
      else if (i / 4 < cap_cyc.size())
        checkOutput($sformatf("%s/lat%0d", name, i), obs_cyc[i] - cap_cyc[i/4], gap);
    end
  endtask

  initial begin
    logic [383:0] x;
    int kpt, rn, w;
    rst_n = 1'b0; start = 1'b0; kpt_num = '0; ref_num = '0; dist_thresh = '0;
    for (int i = 0; i < 256; i++) ref_mem[i] = rand_dims();
    #23;
    checkQuiet("reset_outputs");
    @(posedge clk); #1;
    rst_n = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    checkQuiet("idle_after_reset");

    ref_mem[0] = flat_dims(0); ref_mem[1] = flat_dims(5); ref_mem[2] = flat_dims(2);
    desc_q.push_back({9'd10, 10'd20, flat_dims(2)});
    for (int j = 0; j < 3; j++) desc_q.push_back({9'(j + 1), 10'(j + 100), flat_dims(7)});
    applyStimulus("basic", 4, 3, 100, 2, 0, 1'b0);
    if (obs_idx.size() == 4) begin
      checkOutput("basic/q1_idx_const", obs_idx[0], 2);
      checkOutput("basic/q1_dist_const", obs_dist[0], 0);
      checkOutput("basic/q2_idx_const", obs_idx[1], 1);
      checkOutput("basic/q2_dist_const", obs_dist[1], 64);
    end

    for (int i = 0; i < 16; i++) ref_mem[i] = rand_dims();
    for (int j = 0; j < 4; j++) desc_q.push_back(rand_desc());
    applyStimulus("rem6", 6, 4, 60000, 0, 0, 1'b0);
    applyStimulus("rem3", 3, 4, 60000, 0, 0, 1'b0);

    x = rand_dims();
    ref_mem[0] = x; ref_mem[1] = x;
    for (int j = 0; j < 4; j++) desc_q.push_back({9'(j), 10'(j * 3), x});
    applyStimulus("tie_t0", 4, 2, 0, 0, 0, 1'b0);
    if (obs_hit.size() > 0) checkOutput("tie_t0/hit_const", obs_hit[0], 0);
    for (int j = 0; j < 4; j++) desc_q.push_back({9'(j), 10'(j * 3), x});
    applyStimulus("tie_t1", 4, 2, 1, 0, 0, 1'b0);
    if (obs_hit.size() > 0) checkOutput("tie_t1/hit_const", obs_hit[0], 1);

    ref_mem[0] = flat_dims(0);
    for (int j = 0; j < 4; j++) desc_q.push_back({9'd511, 10'd1023, flat_dims(4095)});
    applyStimulus("extreme", 4, 1, 'h1FFFF, 0, 0, 1'b0);
    if (obs_dist.size() > 0) checkOutput("extreme/dist_const", obs_dist[0], 131040);
    for (int j = 0; j < 4; j++) desc_q.push_back(rand_desc());
    applyStimulus("empty_ref", 4, 0, 'h1FFFF, 0, 0, 1'b0);
    if (obs_dist.size() > 0) checkOutput("empty_ref/dist_const", obs_dist[0], 'h1FFFF);

    for (int i = 0; i < 16; i++) ref_mem[i] = rand_dims();
    for (int j = 0; j < 8; j++) desc_q.push_back(rand_desc());
    applyStimulus("stall", 8, 5, 40000, 20, 3, 1'b1);

    for (int f = 0; f < 6; f++) begin
      kpt = $urandom_range(0, 14);
      rn = $urandom_range(0, 12);
      for (int i = 0; i < 16; i++) ref_mem[i] = rand_dims();
      for (int j = 0; j < (kpt / 4) * 4; j++) desc_q.push_back(rand_desc());
      applyStimulus($sformatf("rand%0d", f), kpt, rn, $urandom_range(0, 90000),
                    $urandom_range(0, 4), 0, (rn >= 4) && (kpt >= 4));
    end

    // Abort a frame while the second group is being swept, then run a clean one.
    for (int j = 0; j < 8; j++) desc_q.push_back(rand_desc());
    cap_cyc.delete();
    gen_delay = 1; gen_stray = 0;
    @(posedge clk); #1;
    kpt_num = 11'd8; ref_num = 9'd10; dist_thresh = 17'd50000; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    w = 0;
    while (cap_cyc.size() < 2 && w < 3000) begin
      @(posedge clk); #1;
      w++;
    end
    checkOutput("rst/reached_group2", cap_cyc.size(), 2);
    repeat (2) @(posedge clk);
    #1;
    checkOutput("rst/sweep_addr", ref_addr, 2);
    #2;
    rst_n = 1'b0;
    #1;
    checkQuiet("rst/async_clear");
    repeat (3) @(posedge clk);
    #1;
    checkQuiet("rst/held");
    rst_n = 1'b1;
    desc_q.delete();
    for (int i = 0; i < 16; i++) ref_mem[i] = rand_dims();
    for (int j = 0; j < 8; j++) desc_q.push_back(rand_desc());
    applyStimulus("post_reset", 8, 6, 50000, 1, 0, 1'b0);

    $display("test done: total=%0d bad=%0d", total_checks, bad_checks);
    $finish;
  end

endmodule
